// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the three-digit multiplexed seven-segment driver.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    localparam int unsigned DIGITS = 3;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned BCD_W  = 4;

    localparam logic [SEG_W-1:0] GLYPH_0     = 7'h40;
    localparam logic [SEG_W-1:0] GLYPH_1     = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_2     = 7'h24;
    localparam logic [SEG_W-1:0] GLYPH_3     = 7'h30;
    localparam logic [SEG_W-1:0] GLYPH_4     = 7'h19;
    localparam logic [SEG_W-1:0] GLYPH_5     = 7'h12;
    localparam logic [SEG_W-1:0] GLYPH_6     = 7'h02;
    localparam logic [SEG_W-1:0] GLYPH_7     = 7'h78;
    localparam logic [SEG_W-1:0] GLYPH_8     = 7'h00;
    localparam logic [SEG_W-1:0] GLYPH_9     = 7'h10;
    localparam logic [SEG_W-1:0] GLYPH_DASH  = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ONES     = 2'd0,
        TENS     = 2'd1,
        HUNDREDS = 2'd2
    } digit_idx_e;

    typedef struct packed {
        logic [BCD_W-1:0] hundreds;
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } digits_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = GLYPH_DASH;
        case (bcd)
            4'd0:    seg_c = GLYPH_0;
            4'd1:    seg_c = GLYPH_1;
            4'd2:    seg_c = GLYPH_2;
            4'd3:    seg_c = GLYPH_3;
            4'd4:    seg_c = GLYPH_4;
            4'd5:    seg_c = GLYPH_5;
            4'd6:    seg_c = GLYPH_6;
            4'd7:    seg_c = GLYPH_7;
            4'd8:    seg_c = GLYPH_8;
            4'd9:    seg_c = GLYPH_9;
            default: seg_c = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed three-digit seven-segment driver with double-buffered digits and anti-ghost guard.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zeros on the hundreds/tens digits.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BCD_W-1:0]  hundreds,
    input  logic [BCD_W-1:0]  tens,
    input  logic [BCD_W-1:0]  ones,
    output logic [SEG_W-1:0]  seg,
    output logic [DIGITS-1:0] an,
    output logic              frame_done
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0]  cnt;
    logic              tick_c;
    logic              boundary_c;
    logic              in_guard_c;
    logic              lz_blank_c;
    digit_idx_e        idx;
    digit_idx_e        idx_next_c;
    digits_t           shadow;
    digits_t           display;
    digits_t           load_val_c;
    logic [BCD_W-1:0]  digit_c;
    logic [SEG_W-1:0]  glyph_c;
    logic [SEG_W-1:0]  seg_next_c;
    logic [DIGITS-1:0] an_next_c;
    logic              frame_done_next_c;

    assign tick_c     = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign boundary_c = tick_c && (idx == HUNDREDS);
    assign load_val_c = {hundreds, tens, ones};

    // Guard window is empty when GUARD is zero; avoid a constant compare in that case.
    if (GUARD == 0) begin : g_no_guard
        assign in_guard_c = 1'b0;
    end else begin : g_guard
        assign in_guard_c = (cnt < CNT_W'(GUARD));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow captures every load; display takes the shadow (or the coincident load) at the boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow  <= '0;
            display <= '0;
        end else begin
            if (load) begin
                shadow <= load_val_c;
            end
            if (boundary_c) begin
                display <= load ? load_val_c : shadow;
            end
        end
    end

    always_comb begin
        digit_c    = display.ones;
        lz_blank_c = 1'b0;
        case (idx)
            ONES:     digit_c = display.ones;
            TENS:     digit_c = display.tens;
            HUNDREDS: digit_c = display.hundreds;
            default:  digit_c = display.ones;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == HUNDREDS && display.hundreds == '0) begin
            lz_blank_c = 1'b1;
        end
        if (idx == TENS && display.hundreds == '0 && display.tens == '0) begin
            lz_blank_c = 1'b1;
        end
`endif
    end

    bcd_to_seg u_dec (
        .bcd   (digit_c),
        .seg_c (glyph_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= ONES;
        end else begin
            idx <= idx_next_c;
        end
    end

    always_comb begin
        idx_next_c        = idx;
        seg_next_c        = GLYPH_BLANK;
        an_next_c         = '1;
        frame_done_next_c = boundary_c;

        if (tick_c) begin
            case (idx)
                ONES:     idx_next_c = TENS;
                TENS:     idx_next_c = HUNDREDS;
                HUNDREDS: idx_next_c = ONES;
                default:  idx_next_c = ONES;
            endcase
        end

        if (!in_guard_c && !lz_blank_c) begin
            seg_next_c = glyph_c;
            case (idx)
                ONES:     an_next_c = 3'b110;
                TENS:     an_next_c = 3'b101;
                HUNDREDS: an_next_c = 3'b011;
                default:  an_next_c = 3'b111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg        <= GLYPH_BLANK;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next_c;
            an         <= an_next_c;
            frame_done <= frame_done_next_c;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan (REFRESH_DIV=8, GUARD=2) with directed frame-level checks.
module tb_seven_seg_scan;

    localparam int unsigned RD = 8;
    localparam int unsigned GD = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [6:0] seg;
        logic [2:0] an;
        logic       fd;
    } obs_t;

    obs_t exp_q[$];

    int         m_cnt;
    int         m_idx;
    logic [3:0] m_sh [3];
    logic [3:0] m_dp [3];

    logic [6:0] f_seg [3];
    int         f_lit [3];
    int         f_blank;
    int         f_fd_count;
    int         f_fd_pos;

    seven_seg_scan #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Reference model: predicts outputs after the coming edge from current inputs and model state.
    task automatic predict();
        obs_t e;
        bit   lit;
        logic [3:0] in_d [3];
        in_d[0] = ones;
        in_d[1] = tens;
        in_d[2] = hundreds;
        if (!rst_n) begin
            e = {7'h7F, 3'b111, 1'b0};
            m_cnt = 0;
            m_idx = 0;
            for (int i = 0; i < 3; i++) begin
                m_sh[i] = 4'd0;
                m_dp[i] = 4'd0;
            end
        end else begin
            lit = (m_cnt >= int'(GD));
`ifdef LEADING_ZERO_BLANK_EN
            if (m_idx == 2 && m_dp[2] == 4'd0) lit = 1'b0;
            if (m_idx == 1 && m_dp[2] == 4'd0 && m_dp[1] == 4'd0) lit = 1'b0;
`endif
            e.an  = lit ? ~(3'b001 << m_idx) : 3'b111;
            e.seg = lit ? ref_glyph(m_dp[m_idx]) : 7'h7F;
            e.fd  = (m_cnt == int'(RD) - 1) && (m_idx == 2);
            if (m_cnt == int'(RD) - 1) begin
                if (m_idx == 2) begin
                    for (int i = 0; i < 3; i++) m_dp[i] = load ? in_d[i] : m_sh[i];
                end
                m_idx = (m_idx + 1) % 3;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            if (load) begin
                for (int i = 0; i < 3; i++) m_sh[i] = in_d[i];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic ld, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        obs_t e;
        @(negedge clk);
        rst_n    = r;
        load     = ld;
        hundreds = h;
        tens     = t;
        ones     = o;
        predict();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb_seg", 32'(seg), 32'(e.seg));
            check("sb_an", 32'(an), 32'(e.an));
            check("sb_fd", 32'(frame_done), 32'(e.fd));
        end
    endtask

    task automatic wait_fd(input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
            if (frame_done === 1'b1) break;
        end
        check("fd_seen", 32'(frame_done), 32'd1);
    endtask

    task automatic wait_lit(input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
            if (an !== 3'b111) break;
        end
    endtask

    // Runs one full frame (24 cycles) after a frame_done, optionally loading at a given cycle.
    task automatic collect_frame(input int load_at, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        for (int i = 0; i < 3; i++) begin
            f_seg[i] = 7'h7F;
            f_lit[i] = 0;
        end
        f_blank    = 0;
        f_fd_count = 0;
        f_fd_pos   = -1;
        for (int c = 0; c < 3 * int'(RD); c++) begin
            if (c == load_at) cycle(1'b1, 1'b1, h, t, o);
            else              cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
            case (an)
                3'b110: begin f_lit[0]++; f_seg[0] = seg; end
                3'b101: begin f_lit[1]++; f_seg[1] = seg; end
                3'b011: begin f_lit[2]++; f_seg[2] = seg; end
                3'b111: f_blank++;
                default: ;
            endcase
            if (frame_done === 1'b1) begin
                f_fd_count++;
                f_fd_pos = c;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        hundreds = 4'd0;
        tens     = 4'd0;
        ones     = 4'd0;
        m_cnt    = 0;
        m_idx    = 0;
        for (int i = 0; i < 3; i++) begin
            m_sh[i] = 4'd0;
            m_dp[i] = 4'd0;
        end

        repeat (3) cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'b111);
        check("rst_fd", 32'(frame_done), 32'd0);
        wait_lit(20);
        check("first_an", 32'(an), 32'b110);
        check("first_seg", 32'(seg), 32'h40);

        // Load 1,2,3 and inspect the following frame, including guard and pulse cadence.
        cycle(1'b1, 1'b1, 4'd1, 4'd2, 4'd3);
        wait_fd(40);
        collect_frame(-1, 4'd0, 4'd0, 4'd0);
        check("l123_ones", 32'(f_seg[0]), 32'h30);
        check("l123_tens", 32'(f_seg[1]), 32'h24);
        check("l123_hund", 32'(f_seg[2]), 32'h79);
        check("guard_cycles", 32'(f_blank), 32'(3 * GD));
        check("lit_ones", 32'(f_lit[0]), 32'(RD - GD));
        check("lit_tens", 32'(f_lit[1]), 32'(RD - GD));
        check("lit_hund", 32'(f_lit[2]), 32'(RD - GD));
        check("fd_count", 32'(f_fd_count), 32'd1);
        check("fd_period", 32'(f_fd_pos), 32'(3 * RD - 1));

        // Load coinciding with the HUNDREDS tick is forwarded into the very next frame.
        collect_frame(3 * int'(RD) - 1, 4'd4, 4'd5, 4'd6);
        check("bnd_fd", 32'(frame_done), 32'd1);
        collect_frame(-1, 4'd0, 4'd0, 4'd0);
        check("bnd_ones", 32'(f_seg[0]), 32'h02);
        check("bnd_tens", 32'(f_seg[1]), 32'h12);
        check("bnd_hund", 32'(f_seg[2]), 32'h19);

        // Mid-frame load leaves the current frame alone.
        collect_frame(9, 4'd7, 4'd8, 4'd9);
        check("mid_ones_keep", 32'(f_seg[0]), 32'h02);
        check("mid_hund_keep", 32'(f_seg[2]), 32'h19);
        collect_frame(-1, 4'd0, 4'd0, 4'd0);
        check("l789_ones", 32'(f_seg[0]), 32'h10);
        check("l789_tens", 32'(f_seg[1]), 32'h00);
        check("l789_hund", 32'(f_seg[2]), 32'h78);

        // Non-BCD ones digit renders as a dash.
        collect_frame(5, 4'd1, 4'd2, 4'hC);
        collect_frame(-1, 4'd0, 4'd0, 4'd0);
        check("dash_ones", 32'(f_seg[0]), 32'h3F);

        collect_frame(5, 4'd0, 4'd0, 4'd7);
        collect_frame(-1, 4'd0, 4'd0, 4'd0);
        check("l007_ones", 32'(f_seg[0]), 32'h78);
`ifdef LEADING_ZERO_BLANK_EN
        check("lzb_tens_dark", 32'(f_lit[1]), 32'd0);
        check("lzb_hund_dark", 32'(f_lit[2]), 32'd0);
`else
        check("l007_tens", 32'(f_seg[1]), 32'h40);
        check("l007_hund", 32'(f_seg[2]), 32'h40);
`endif

        // Reset mid-operation discards displayed content.
        collect_frame(3, 4'd9, 4'd9, 4'd9);
        repeat (10) cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        check("mrst_seg", 32'(seg), 32'h7F);
        check("mrst_an", 32'(an), 32'b111);
        wait_lit(20);
        check("mrst_an_lit", 32'(an), 32'b110);
        check("mrst_seg_zero", 32'(seg), 32'h40);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
